// File: rtl/sonic_cb_tx_gearbox_pkg.sv
// Shared widths and gearbox operation codes for the SONIC TX circular buffer.
package sonic_cb_tx_gearbox_pkg;

  localparam int unsigned SONIC_DMA_W    = 128;
  localparam int unsigned SONIC_PCS_W    = 40;
  localparam int unsigned SONIC_CB_DEPTH = 16;

  typedef enum logic [2:0] {
    GB_IDLE,
    GB_SHIFT,
    GB_POP_SHIFT,
    GB_UNDERFLOW,
    GB_PREFETCH,
    GB_FLUSH
  } gb_op_e;

endpackage

// File: rtl/sonic_cb_tx_gearbox_if.sv
// DMA write / PCS read / status bundle of the TX circular buffer.
interface sonic_cb_tx_gearbox_if #(
  parameter int unsigned IN_W  = sonic_cb_tx_gearbox_pkg::SONIC_DMA_W,
  parameter int unsigned OUT_W = sonic_cb_tx_gearbox_pkg::SONIC_PCS_W,
  parameter int unsigned AW    = $clog2(sonic_cb_tx_gearbox_pkg::SONIC_CB_DEPTH)
);

  logic             wr_valid;
  logic [IN_W-1:0]  wr_data;
  logic             wr_ready;
  logic             rd_en;
  logic [OUT_W-1:0] rd_data;
  logic             rd_valid;
  logic             underflow;
  logic [AW:0]      level;
  logic [AW:0]      af_thresh;
  logic             almost_full;

  modport master (
    output wr_valid, wr_data, rd_en, af_thresh,
    input  wr_ready, rd_data, rd_valid, underflow, level, almost_full
  );

  modport slave (
    input  wr_valid, wr_data, rd_en, af_thresh,
    output wr_ready, rd_data, rd_valid, underflow, level, almost_full
  );

endinterface

// File: rtl/sonic_cb_tx_gearbox_gearbox.sv
// Width gearbox: LSB-first residue shift register feeding registered output words.
module sonic_cb_gearbox
  import sonic_cb_tx_gearbox_pkg::*;
#(
  parameter int unsigned      IN_W      = SONIC_DMA_W,
  parameter int unsigned      OUT_W     = SONIC_PCS_W,
  parameter logic [OUT_W-1:0] IDLE_WORD = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rd_en,
  input  logic             avail,
  input  logic [IN_W-1:0]  ram_data,
  output logic             pop_c,
  output logic [OUT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             underflow
);

  localparam int unsigned SRW = IN_W + OUT_W;
  localparam int unsigned BCW = $clog2(SRW);

  gb_op_e         op_c;
  logic [SRW-1:0] sr;
  logic [SRW-1:0] merged_c;
  logic [BCW-1:0] bc;

  // Next RAM word appended above the bc residue bits.
  assign merged_c = sr | (SRW'(ram_data) << bc);

  always_comb begin
    op_c = GB_IDLE;
    if (flush)                       op_c = GB_FLUSH;
    else if (rd_en) begin
      if (bc >= BCW'(OUT_W))         op_c = GB_SHIFT;
      else if (avail)                op_c = GB_POP_SHIFT;
      else                           op_c = GB_UNDERFLOW;
    end else if ((bc < BCW'(OUT_W)) && avail) begin
      op_c = GB_PREFETCH;
    end
  end

  assign pop_c = (op_c == GB_POP_SHIFT) || (op_c == GB_PREFETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      bc        <= '0;
      rd_data   <= IDLE_WORD;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
      case (op_c)
        GB_FLUSH: begin
          sr <= '0;
          bc <= '0;
          if (rd_en) rd_data <= IDLE_WORD;
        end
        GB_SHIFT: begin
          rd_data  <= sr[OUT_W-1:0];
          rd_valid <= 1'b1;
          sr       <= sr >> OUT_W;
          bc       <= bc - BCW'(OUT_W);
        end
        GB_POP_SHIFT: begin
          rd_data  <= merged_c[OUT_W-1:0];
          rd_valid <= 1'b1;
          sr       <= merged_c >> OUT_W;
          bc       <= bc + BCW'(IN_W - OUT_W);
        end
        GB_UNDERFLOW: begin
          rd_data   <= IDLE_WORD;
          underflow <= 1'b1;
        end
        GB_PREFETCH: begin
          sr <= merged_c;
          bc <= bc + BCW'(IN_W);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sonic_cb_tx_gearbox.sv
// TX circular buffer: flop RAM, pointers, level and flow control around the width gearbox.
module sonic_cb_tx_gearbox
  import sonic_cb_tx_gearbox_pkg::*;
#(
  parameter int unsigned               DATA_IN_WIDTH  = SONIC_DMA_W,
  parameter int unsigned               DATA_OUT_WIDTH = SONIC_PCS_W,
  parameter int unsigned               DEPTH          = SONIC_CB_DEPTH,
  parameter logic [DATA_OUT_WIDTH-1:0] IDLE_WORD      = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 flush,
  sonic_cb_tx_gearbox_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_IN_WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [LW-1:0]            level;
  logic [LW-1:0]            level_next;
  logic                     wr_ready;
  logic                     we_c;
  logic                     pop_c;

  assign we_c = bus.wr_valid & wr_ready & ~flush;

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      case ({we_c, pop_c})
        2'b10:   level_next = level + LW'(1);
        2'b01:   level_next = level - LW'(1);
        default: level_next = level;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (we_c) ram[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wr_ready <= 1'b0;
    end else begin
      level    <= level_next;
      wr_ready <= (level_next < LW'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (we_c)  wr_ptr <= wr_ptr + AW'(1);
        if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.level       = level;
  assign bus.almost_full = (level >= bus.af_thresh);

  sonic_cb_gearbox #(
    .IN_W      (DATA_IN_WIDTH),
    .OUT_W     (DATA_OUT_WIDTH),
    .IDLE_WORD (IDLE_WORD)
  ) u_gearbox (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rd_en     (bus.rd_en),
    .avail     (level != '0),
    .ram_data  (ram[rd_ptr]),
    .pop_c     (pop_c),
    .rd_data   (bus.rd_data),
    .rd_valid  (bus.rd_valid),
    .underflow (bus.underflow)
  );

endmodule

// File: tb/tb_sonic_cb_tx_gearbox.sv
// Directed bench for the 128->40 TX circular buffer with gearbox.
module tb_sonic_cb_tx_gearbox;

  localparam int unsigned IN_W  = 128;
  localparam int unsigned OUT_W = 40;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [OUT_W-1:0] IDLE = 40'hA5_5A5A_A5A5;

  logic clk;
  logic rst_n;
  logic flush;

  int unsigned n_total;
  int unsigned n_bad;

  logic [IN_W-1:0] w [5];
  logic [IN_W-1:0] u [18];
  logic [IN_W-1:0] v0;
  logic [IN_W-1:0] v1;
  logic [639:0]    stream;

  sonic_cb_tx_gearbox_if #(.IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) bus ();

  sonic_cb_tx_gearbox #(
    .DATA_IN_WIDTH  (IN_W),
    .DATA_OUT_WIDTH (OUT_W),
    .DEPTH          (DEPTH),
    .IDLE_WORD      (IDLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    flush = 1'b0;
    n_total = 0;
    n_bad = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data = 128'h1234;
    bus.rd_en = 1'b0;
    bus.af_thresh = 5'd12;

    for (int i = 0; i < 5; i++) begin
      w[i] = {32'hDEADBEEF ^ 32'(i), 32'h01234567 + 32'(i), 32'h89ABCDEF - 32'(i), 32'(i * 7 + 3)};
      stream[i*128 +: 128] = w[i];
    end
    for (int i = 0; i < 18; i++) u[i] = {4{32'hC0DE0000 + 32'(i)}};
    v0 = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    v1 = 128'h13579BDF_2468ACE0_55AA55AA_CAFEF00D;

    // T1: reset held with wr_valid high
    repeat (3) step();
    chk("rst_wr_ready", 128'(bus.wr_ready), 128'(0));
    chk("rst_level", 128'(bus.level), 128'(0));
    chk("rst_rd_data", 128'(bus.rd_data), 128'(IDLE));
    chk("rst_rd_valid", 128'(bus.rd_valid), 128'(0));
    chk("rst_underflow", 128'(bus.underflow), 128'(0));
    bus.wr_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rel_wr_ready", 128'(bus.wr_ready), 128'(1));
    chk("rel_level", 128'(bus.level), 128'(0));

    // T2: 5 x 128 in, 16 x 40 out
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data = w[i];
      step();
    end
    bus.wr_valid = 1'b0;
    step();
    bus.rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("t2_valid", 128'(bus.rd_valid), 128'(1));
      chk("t2_data", 128'(bus.rd_data), 128'(stream[k*40 +: 40]));
    end
    step();
    chk("t2_uf", 128'(bus.underflow), 128'(1));
    chk("t2_uf_valid", 128'(bus.rd_valid), 128'(0));
    chk("t2_uf_data", 128'(bus.rd_data), 128'(IDLE));
    chk("t2_level", 128'(bus.level), 128'(0));
    bus.rd_en = 1'b0;
    step();
    chk("t2_uf_pulse", 128'(bus.underflow), 128'(0));

    // T3: fill; first word is prefetched into the gearbox, so 17 are accepted
    for (int k = 0; k < 18; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data = u[k];
      step();
      if (k == 11) chk("t3_af_lo", 128'(bus.almost_full), 128'(0));
      if (k == 12) chk("t3_af_hi", 128'(bus.almost_full), 128'(1));
      if (k == 15) chk("t3_rdy_15", 128'(bus.wr_ready), 128'(1));
      if (k == 16) begin
        chk("t3_rdy_16", 128'(bus.wr_ready), 128'(0));
        chk("t3_level_16", 128'(bus.level), 128'(16));
      end
    end
    bus.wr_valid = 1'b0;
    chk("t3_level_full", 128'(bus.level), 128'(16));
    bus.af_thresh = 5'd17;
    #1 chk("t3_af_over", 128'(bus.almost_full), 128'(0));
    bus.af_thresh = 5'd16;
    #1 chk("t3_af_eq", 128'(bus.almost_full), 128'(1));
    bus.af_thresh = 5'd0;
    #1 chk("t3_af_zero", 128'(bus.almost_full), 128'(1));
    bus.af_thresh = 5'd12;
    @(negedge clk);
    @(posedge clk);
    #1;

    // T5: drain residue, then read+write at full
    bus.rd_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t5_valid", 128'(bus.rd_valid), 128'(1));
      chk("t5_data", 128'(bus.rd_data), 128'(u[0][j*40 +: 40]));
    end
    bus.wr_valid = 1'b1;
    bus.wr_data = 128'hBAD;
    step();
    chk("t5_data_join", 128'(bus.rd_data), 128'({u[1][31:0], u[0][127:120]}));
    chk("t5_level", 128'(bus.level), 128'(15));
    chk("t5_rdy", 128'(bus.wr_ready), 128'(1));
    bus.wr_valid = 1'b0;

    // T6: flush with rd_en
    flush = 1'b1;
    step();
    chk("t6_level", 128'(bus.level), 128'(0));
    chk("t6_valid", 128'(bus.rd_valid), 128'(0));
    chk("t6_uf", 128'(bus.underflow), 128'(0));
    chk("t6_data", 128'(bus.rd_data), 128'(IDLE));
    flush = 1'b0;
    bus.rd_en = 1'b0;
    step();
    chk("t6_rdy", 128'(bus.wr_ready), 128'(1));

    // T4: underflow with 8 residue bits held
    bus.wr_valid = 1'b1;
    bus.wr_data = v0;
    step();
    bus.wr_valid = 1'b0;
    bus.rd_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t4_valid", 128'(bus.rd_valid), 128'(1));
      chk("t4_data", 128'(bus.rd_data), 128'(v0[j*40 +: 40]));
    end
    step();
    chk("t4_uf", 128'(bus.underflow), 128'(1));
    chk("t4_uf_valid", 128'(bus.rd_valid), 128'(0));
    bus.rd_en = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data = v1;
    step();
    bus.wr_valid = 1'b0;
    bus.rd_en = 1'b1;
    step();
    chk("t4_join_valid", 128'(bus.rd_valid), 128'(1));
    chk("t4_join_data", 128'(bus.rd_data), 128'({v1[31:0], v0[127:120]}));

    // Async reset mid-cycle
    bus.wr_valid = 1'b1;
    bus.wr_data = v0;
    step();
    chk("ar_pre_valid", 128'(bus.rd_valid), 128'(1));
    chk("ar_pre_level", 128'(bus.level), 128'(1));
    bus.wr_valid = 1'b0;
    bus.rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(bus.rd_valid), 128'(0));
    chk("ar_data", 128'(bus.rd_data), 128'(IDLE));
    chk("ar_level", 128'(bus.level), 128'(0));
    chk("ar_rdy", 128'(bus.wr_ready), 128'(0));
    chk("ar_af", 128'(bus.almost_full), 128'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
